// File: rtl/rv32imf_pkg.sv
// Shared types and constants for the rv32imf memory-side blocks.
// Holds the OBI arbiter FSM encoding and the requester ID values.
package rv32imf_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LOCK_I = 2'd1,
    ARB_LOCK_D = 2'd2
  } arb_state_e;

  localparam logic ARB_ID_INSTR = 1'b0;
  localparam logic ARB_ID_DATA  = 1'b1;

  // Round-robin choice on a tie: the requester that was not granted last.
  function automatic logic arb_rr_pick(input logic last_id);
    return ~last_id;
  endfunction

endpackage

// File: rtl/rv32imf_obi_arb_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding memory transactions.
// Pointers wrap modulo DEPTH, so any DEPTH >= 1 is supported.
module rv32imf_obi_arb_id_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             push_id,
  input  logic             pop,
  output logic             head,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  logic [DEPTH-1:0] id_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && (cnt_q != '0);
  assign head    = id_q[rd_ptr_q];
  assign cnt     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        id_q[wr_ptr_q] <= push_id;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/rv32imf_obi_arbiter.sv
// Two-to-one OBI arbiter sharing one memory port between instruction prefetch
// and the load/store unit; responses are routed through an in-order ID FIFO.
module rv32imf_obi_arbiter
  import rv32imf_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned RR_ARB          = 0,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  // Handshake: a request is accepted in a cycle where mem_req_o && mem_gnt_i;
  // each accepted request is answered by exactly one mem_rvalid_i, in order.

  arb_state_e       state_q;
  arb_state_e       state_d;
  logic             last_q;
  logic             idle_sel;
  logic             sel;
  logic             any_req;
  logic             accept;
  logic             rsp_ok;
  logic             fifo_head;
  logic             fifo_full;
  logic [CNT_W-1:0] cnt_q;

  assign any_req   = instr_req_i || data_req_i;
  assign mem_req_o = any_req && !fifo_full;
  assign accept    = mem_req_o && mem_gnt_i;

  always_comb begin
    idle_sel = ARB_ID_INSTR;
    if (instr_req_i && data_req_i) begin
      idle_sel = (RR_ARB != 0) ? arb_rr_pick(last_q) : ARB_ID_DATA;
    end else if (data_req_i) begin
      idle_sel = ARB_ID_DATA;
    end
  end

  // A lock only forces the selection while the locked requester still asks;
  // otherwise the idle choice applies so no grant goes to an idle requester.
  always_comb begin
    sel     = idle_sel;
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (mem_req_o && !mem_gnt_i) begin
          state_d = (idle_sel == ARB_ID_DATA) ? ARB_LOCK_D : ARB_LOCK_I;
        end
      end
      ARB_LOCK_I: begin
        if (instr_req_i) begin
          sel = ARB_ID_INSTR;
          if (accept) state_d = ARB_IDLE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_LOCK_D: begin
        if (data_req_i) begin
          sel = ARB_ID_DATA;
          if (accept) state_d = ARB_IDLE;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= ARB_ID_INSTR;
    end else begin
      state_q <= state_d;
      if (accept) last_q <= sel;
    end
  end

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    if (any_req) begin
      if (sel == ARB_ID_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o = instr_addr_i;
        mem_be_o   = 4'b1111;
      end
    end
  end

  assign instr_gnt_o = accept && (sel == ARB_ID_INSTR);
  assign data_gnt_o  = accept && (sel == ARB_ID_DATA);

  rv32imf_obi_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .push_id (sel),
    .pop     (mem_rvalid_i),
    .head    (fifo_head),
    .cnt     (cnt_q),
    .full    (fifo_full)
  );

  // Responses with nothing outstanding are dropped.
  assign rsp_ok         = mem_rvalid_i && (cnt_q != '0);
  assign instr_rvalid_o = rsp_ok && (fifo_head == ARB_ID_INSTR);
  assign data_rvalid_o  = rsp_ok && (fifo_head == ARB_ID_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign instr_err_o    = mem_err_i;
  assign data_err_o     = mem_err_i;

endmodule
